insn_encoder: RTL

//  Streaming RV32IM instruction encoder: exact inverse of the core's instruction decoder.

---
 rtl/insn_encoder_pkg.sv | 89 ++++++++
 rtl/insn_enc_fields.sv | 72 +++++++
 rtl/insn_encoder.sv | 96 +++++++++
 3 files changed

// File: rtl/insn_encoder_pkg.sv
// rtl/insn_encoder_pkg.sv - RV32IM encoder op set, opcode/funct constants and format packers
package insn_encoder_pkg;

    // The 35 ops the core decoder supports; any other in_op value encodes as NOP with error.
    typedef enum logic [5:0] {
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_XOR, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU
    } op_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_JALR   = 3'b000;
    localparam logic [2:0] F3_BEQ    = 3'b000;
    localparam logic [2:0] F3_BNE    = 3'b001;
    localparam logic [2:0] F3_BLT    = 3'b100;
    localparam logic [2:0] F3_BGE    = 3'b101;
    localparam logic [2:0] F3_BLTU   = 3'b110;
    localparam logic [2:0] F3_BGEU   = 3'b111;
    localparam logic [2:0] F3_B      = 3'b000;
    localparam logic [2:0] F3_H      = 3'b001;
    localparam logic [2:0] F3_W      = 3'b010;
    localparam logic [2:0] F3_BU     = 3'b100;
    localparam logic [2:0] F3_HU     = 3'b101;
    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_SLTU   = 3'b011;
    localparam logic [2:0] F3_XOR    = 3'b100;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    function automatic logic [31:0] fmt_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] fmt_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] fmt_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [6:0] opc);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
    endfunction

    // imm[0] of a branch offset is implied zero and never stored
    function automatic logic [31:0] fmt_b(input logic [12:1] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [6:0] opc);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
    endfunction

    function automatic logic [31:0] fmt_u(input logic [19:0] imm_hi, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm_hi, rd, opc};
    endfunction

    function automatic logic [31:0] fmt_j(input logic [20:1] imm, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
    endfunction

endpackage

// File: rtl/insn_enc_fields.sv
// rtl/insn_enc_fields.sv - combinational op+fields to RV32IM machine word with range check
// Ports: op/rd/rs1/rs2/imm symbolic command in; insn encoded word out; err set for
// out-of-range imm or unsupported op (word still emitted with truncated fields, NOP if unsupported).
module insn_enc_fields
    import insn_encoder_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] insn,
    output logic        err
);

    logic signed [31:0] simm;
    logic ok_i_s, ok_i_u, ok_b_s, ok_b_u, ok_j, ok_u;

    assign simm = imm;

    // Unsigned-flag ops are zero-extended by the decoder, so negative values cannot round-trip.
    assign ok_i_s = (simm >= -32'sd2048) && (simm <= 32'sd2047);
    assign ok_i_u = (imm <= 32'd4095);
    assign ok_b_s = !imm[0] && (simm >= -32'sd4096) && (simm <= 32'sd4094);
    assign ok_b_u = !imm[0] && (imm <= 32'd8190);
    assign ok_j   = !imm[0] && (simm >= -32'sd1048576) && (simm <= 32'sd1048574);
    assign ok_u   = (imm[11:0] == 12'h000);

    always_comb begin
        insn = NOP_INSN;
        err  = 1'b0;
        case (op)
            OP_LUI:    begin insn = fmt_u(imm[31:12], rd, OPC_LUI);           err = !ok_u;   end
            OP_AUIPC:  begin insn = fmt_u(imm[31:12], rd, OPC_AUIPC);         err = !ok_u;   end
            OP_JAL:    begin insn = fmt_j(imm[20:1], rd, OPC_JAL);            err = !ok_j;   end
            OP_JALR:   begin insn = fmt_i(imm[11:0], rs1, F3_JALR, rd, OPC_JALR); err = !ok_i_s; end
            OP_BEQ:    begin insn = fmt_b(imm[12:1], rs2, rs1, F3_BEQ,  OPC_BRANCH); err = !ok_b_s; end
            OP_BNE:    begin insn = fmt_b(imm[12:1], rs2, rs1, F3_BNE,  OPC_BRANCH); err = !ok_b_s; end
            OP_BLT:    begin insn = fmt_b(imm[12:1], rs2, rs1, F3_BLT,  OPC_BRANCH); err = !ok_b_s; end
            OP_BGE:    begin insn = fmt_b(imm[12:1], rs2, rs1, F3_BGE,  OPC_BRANCH); err = !ok_b_s; end
            OP_BLTU:   begin insn = fmt_b(imm[12:1], rs2, rs1, F3_BLTU, OPC_BRANCH); err = !ok_b_u; end
            OP_BGEU:   begin insn = fmt_b(imm[12:1], rs2, rs1, F3_BGEU, OPC_BRANCH); err = !ok_b_u; end
            OP_LB:     begin insn = fmt_i(imm[11:0], rs1, F3_B,  rd, OPC_LOAD);   err = !ok_i_s; end
            OP_LH:     begin insn = fmt_i(imm[11:0], rs1, F3_H,  rd, OPC_LOAD);   err = !ok_i_s; end
            OP_LW:     begin insn = fmt_i(imm[11:0], rs1, F3_W,  rd, OPC_LOAD);   err = !ok_i_s; end
            OP_LBU:    begin insn = fmt_i(imm[11:0], rs1, F3_BU, rd, OPC_LOAD);   err = !ok_i_u; end
            OP_LHU:    begin insn = fmt_i(imm[11:0], rs1, F3_HU, rd, OPC_LOAD);   err = !ok_i_u; end
            OP_SB:     begin insn = fmt_s(imm[11:0], rs2, rs1, F3_B, OPC_STORE);  err = !ok_i_s; end
            OP_SH:     begin insn = fmt_s(imm[11:0], rs2, rs1, F3_H, OPC_STORE);  err = !ok_i_s; end
            OP_SW:     begin insn = fmt_s(imm[11:0], rs2, rs1, F3_W, OPC_STORE);  err = !ok_i_s; end
            OP_ADDI:   begin insn = fmt_i(imm[11:0], rs1, F3_ADD,  rd, OPC_OP_IMM); err = !ok_i_s; end
            OP_SLTI:   begin insn = fmt_i(imm[11:0], rs1, F3_SLT,  rd, OPC_OP_IMM); err = !ok_i_s; end
            OP_SLTIU:  begin insn = fmt_i(imm[11:0], rs1, F3_SLTU, rd, OPC_OP_IMM); err = !ok_i_u; end
            OP_XORI:   begin insn = fmt_i(imm[11:0], rs1, F3_XOR,  rd, OPC_OP_IMM); err = !ok_i_s; end
            OP_ORI:    begin insn = fmt_i(imm[11:0], rs1, F3_OR,   rd, OPC_OP_IMM); err = !ok_i_s; end
            OP_ANDI:   begin insn = fmt_i(imm[11:0], rs1, F3_AND,  rd, OPC_OP_IMM); err = !ok_i_s; end
            OP_ADD:    insn = fmt_r(F7_BASE, rs2, rs1, F3_ADD,    rd, OPC_OP);
            OP_SUB:    insn = fmt_r(F7_SUB,  rs2, rs1, F3_ADD,    rd, OPC_OP);
            OP_SLT:    insn = fmt_r(F7_BASE, rs2, rs1, F3_SLT,    rd, OPC_OP);
            OP_SLTU:   insn = fmt_r(F7_BASE, rs2, rs1, F3_SLTU,   rd, OPC_OP);
            OP_XOR:    insn = fmt_r(F7_BASE, rs2, rs1, F3_XOR,    rd, OPC_OP);
            OP_OR:     insn = fmt_r(F7_BASE, rs2, rs1, F3_OR,     rd, OPC_OP);
            OP_AND:    insn = fmt_r(F7_BASE, rs2, rs1, F3_AND,    rd, OPC_OP);
            OP_MUL:    insn = fmt_r(F7_MUL,  rs2, rs1, F3_MUL,    rd, OPC_OP);
            OP_MULH:   insn = fmt_r(F7_MUL,  rs2, rs1, F3_MULH,   rd, OPC_OP);
            OP_MULHSU: insn = fmt_r(F7_MUL,  rs2, rs1, F3_MULHSU, rd, OPC_OP);
            OP_MULHU:  insn = fmt_r(F7_MUL,  rs2, rs1, F3_MULHU,  rd, OPC_OP);
            default:   begin insn = NOP_INSN; err = 1'b1; end
        endcase
    end

endmodule

// File: rtl/insn_encoder.sv
// rtl/insn_encoder.sv - streaming RV32IM encoder with 2-entry output FIFO and address tagging
// Ports: clk, reset (sync, active-high); in_valid/in_ready + in_op/rd/rs1/rs2/imm command;
// addr_load/addr_init address counter load; out_valid/out_ready + out_insn/out_addr/out_err word;
// err_count saturating count of accepted commands flagged with an error.
module insn_encoder
    import insn_encoder_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int ERR_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_init,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_insn,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [ERR_W-1:0]  err_count
);

    logic [31:0]       enc_insn;
    logic              enc_err;
    logic [31:0]       fifo_insn [2];
    logic [ADDR_W-1:0] fifo_addr [2];
    logic              fifo_err  [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        count, count_next;
    logic [ADDR_W-1:0] addr_ctr, addr_eff;
    logic              push, pop;

    insn_enc_fields u_fields (
        .op   (in_op),
        .rd   (in_rd),
        .rs1  (in_rs1),
        .rs2  (in_rs2),
        .imm  (in_imm),
        .insn (enc_insn),
        .err  (enc_err)
    );

    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign count_next = count + 2'(push) - 2'(pop);
    // A load in the same cycle as an accept tags this word with the new base.
    assign addr_eff   = addr_load ? addr_init : addr_ctr;

    assign out_valid = (count != 2'd0);
    assign out_insn  = fifo_insn[rd_ptr];
    assign out_addr  = fifo_addr[rd_ptr];
    assign out_err   = fifo_err[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= 2'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            in_ready  <= 1'b1;
            addr_ctr  <= '0;
            err_count <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_insn[i] <= '0;
                fifo_addr[i] <= '0;
                fifo_err[i]  <= 1'b0;
            end
        end else begin
            count    <= count_next;
            // Registered from next occupancy, so out_ready never reaches in_ready combinationally.
            in_ready <= (count_next != 2'd2);
            if (push) begin
                fifo_insn[wr_ptr] <= enc_insn;
                fifo_addr[wr_ptr] <= addr_eff;
                fifo_err[wr_ptr]  <= enc_err;
                wr_ptr            <= ~wr_ptr;
                addr_ctr          <= addr_eff + ADDR_W'(4);
            end else if (addr_load) begin
                addr_ctr <= addr_init;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && enc_err && (err_count != '1)) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

endmodule
